// File: rtl/mp_isa_pkg.sv
// ISA definitions shared by the instruction issue stage: opcodes, field ranges,
// the bubble encoding and the issue FSM state type.
package mp_isa_pkg;

  localparam logic [5:0] OP_ADD = 6'd4;
  localparam logic [5:0] OP_XOR = 6'd5;
  localparam logic [5:0] OP_NEG = 6'd6;
  localparam logic [5:0] OP_AVG = 6'd7;
  localparam logic [5:0] OP_ABS = 6'd8;
  localparam logic [5:0] OP_NOT = 6'd9;
  localparam logic [5:0] OP_AND = 6'd10;
  localparam logic [5:0] OP_SUB = 6'd11;
  localparam logic [5:0] OP_OR  = 6'd12;
  localparam logic [5:0] OP_MAX = 6'd13;
  localparam logic [5:0] OP_MIN = 6'd14;

  localparam int OPC_MSB  = 5;
  localparam int OPC_LSB  = 0;
  localparam int SRC1_MSB = 10;
  localparam int SRC1_LSB = 6;
  localparam int SRC2_MSB = 15;
  localparam int SRC2_LSB = 11;
  localparam int DEST_MSB = 20;
  localparam int DEST_LSB = 16;

  localparam logic [31:0] MP_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_STALL = 2'd2
  } issue_state_e;

  function automatic logic is_legal_op(input logic [5:0] opcode);
    return (opcode >= OP_ADD) && (opcode <= OP_MIN);
  endfunction

endpackage

// File: rtl/mp_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head word is read combinationally
// so the issue stage can load it on the same edge it pops.
module mp_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mp_instr_issue.sv
// Instruction queue and issue stage feeding mp_top: filters illegal opcodes on
// enqueue and presents one legal instruction per ISSUE_CYCLES clocks, else a bubble.
module mp_instr_issue
  import mp_isa_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int ISSUE_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic                     hold,
  input  logic                     flush,
  output logic [31:0]              core_instr,
  output logic                     issue_valid,
  output logic                     illegal_pulse,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         issued_count,
  output logic [CNT_W-1:0]         illegal_count,
  output logic                     busy
);

  localparam int CW = $clog2(ISSUE_CYCLES + 1);

  issue_state_e     state_q, state_d, prev_q, prev_d, resume_state;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [31:0]      core_q, core_d;
  logic             issue_valid_q, issue_valid_d;
  logic             illegal_pulse_q, illegal_pulse_d;
  logic [CNT_W-1:0] issued_q, issued_d, illegal_q, illegal_d;

  logic        fifo_full, fifo_empty, fifo_pop, accept, legal;
  logic [31:0] fifo_head;

  assign in_ready        = !fifo_full && !flush;
  assign accept          = in_valid && in_ready;
  assign legal           = is_legal_op(in_instr[OPC_MSB:OPC_LSB]);
  assign illegal_pulse_d = accept && !legal;
  assign illegal_d       = illegal_pulse_d ? illegal_q + CNT_W'(1) : illegal_q;

  mp_sync_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept && legal),
    .din   (in_instr),
    .pop   (fifo_pop),
    .flush (flush),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      prev_q          <= ST_IDLE;
      cnt_q           <= '0;
      core_q          <= MP_NOP;
      issue_valid_q   <= 1'b0;
      illegal_pulse_q <= 1'b0;
      issued_q        <= '0;
      illegal_q       <= '0;
    end else begin
      state_q         <= state_d;
      prev_q          <= prev_d;
      cnt_q           <= cnt_d;
      core_q          <= core_d;
      issue_valid_q   <= issue_valid_d;
      illegal_pulse_q <= illegal_pulse_d;
      issued_q        <= issued_d;
      illegal_q       <= illegal_d;
    end
  end

  // A stall remembers where it came from; on release that state acts in the same cycle.
  assign resume_state = (state_q == ST_STALL) ? prev_q : state_q;

  always_comb begin
    state_d       = state_q;
    prev_d        = prev_q;
    cnt_d         = cnt_q;
    core_d        = core_q;
    issue_valid_d = 1'b0;
    issued_d      = issued_q;
    fifo_pop      = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
      prev_d  = ST_IDLE;
      cnt_d   = '0;
      core_d  = MP_NOP;
    end else if (hold) begin
      if (state_q != ST_STALL) begin
        prev_d  = state_q;
        state_d = ST_STALL;
      end
    end else begin
      state_d = resume_state;
      if (resume_state == ST_ISSUE && cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end else if (!fifo_empty) begin
        fifo_pop      = 1'b1;
        core_d        = fifo_head;
        issue_valid_d = 1'b1;
        issued_d      = issued_q + CNT_W'(1);
        cnt_d         = CW'(ISSUE_CYCLES - 1);
        state_d       = ST_ISSUE;
      end else begin
        core_d  = MP_NOP;
        state_d = ST_IDLE;
      end
    end
  end

  assign core_instr    = core_q;
  assign issue_valid   = issue_valid_q;
  assign illegal_pulse = illegal_pulse_q;
  assign issued_count  = issued_q;
  assign illegal_count = illegal_q;
  assign busy          = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_mp_instr_issue.sv
// Directed bench for mp_instr_issue: a vector table for single-cycle behaviour
// plus hand sequences for reset, full-queue drain and multi-cycle issue with hold.
module tb_mp_instr_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = 32'h0;
  logic        hold = 1'b0;
  logic        flush = 1'b0;

  logic        a_ready, a_iv, a_ip, a_busy;
  logic [31:0] a_core;
  logic [3:0]  a_lvl;
  logic [15:0] a_iss, a_ill;

  logic        b_ready, b_iv, b_ip, b_busy;
  logic [31:0] b_core;
  logic [3:0]  b_lvl;
  logic [15:0] b_iss, b_ill;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mp_instr_issue #(.DEPTH(8), .ISSUE_CYCLES(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_ready), .in_instr(in_instr),
    .hold(hold), .flush(flush), .core_instr(a_core), .issue_valid(a_iv), .illegal_pulse(a_ip),
    .fifo_level(a_lvl), .issued_count(a_iss), .illegal_count(a_ill), .busy(a_busy)
  );

  mp_instr_issue #(.DEPTH(8), .ISSUE_CYCLES(3), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_ready), .in_instr(in_instr),
    .hold(hold), .flush(flush), .core_instr(b_core), .issue_valid(b_iv), .illegal_pulse(b_ip),
    .fifo_level(b_lvl), .issued_count(b_iss), .illegal_count(b_ill), .busy(b_busy)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] instr;
    logic        h;
    logic        f;
    logic [31:0] e_core;
    logic        e_iv;
    logic        e_ip;
    logic [3:0]  e_lvl;
    logic [15:0] e_iss;
    logic [15:0] e_ill;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; hold = 1'b0; flush = 1'b0; in_instr = 32'h0;
    #12;
    rst_n = 1'b1;
    step();
  endtask

  logic [31:0] exp_q [$];
  int          acc_cnt;
  logic [31:0] b_exp_core [1:10];
  logic        b_exp_iv   [1:10];

  initial begin
    //            v     instr          h     f     core           iv    ip    lvl    iss     ill
    vecs[0]  = '{1'b1, 32'h001F1A84, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 4'd1, 16'd0, 16'd0};
    vecs[1]  = '{1'b0, 32'h00000000, 1'b0, 1'b0, 32'h001F1A84, 1'b1, 1'b0, 4'd0, 16'd1, 16'd0};
    vecs[2]  = '{1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 4'd0, 16'd1, 16'd0};
    vecs[3]  = '{1'b1, 32'h00057ACF, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 4'd0, 16'd1, 16'd1};
    vecs[4]  = '{1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 4'd0, 16'd1, 16'd1};
    vecs[5]  = '{1'b1, 32'h00000844, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0, 4'd1, 16'd1, 16'd1};
    vecs[6]  = '{1'b1, 32'h00010845, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0, 4'd2, 16'd1, 16'd1};
    vecs[7]  = '{1'b1, 32'h00020846, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0, 4'd3, 16'd1, 16'd1};
    vecs[8]  = '{1'b1, 32'h00030847, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0, 4'd4, 16'd1, 16'd1};
    vecs[9]  = '{1'b1, 32'h00040848, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0, 4'd5, 16'd1, 16'd1};
    vecs[10] = '{1'b1, 32'h00050849, 1'b1, 1'b1, 32'h00000000, 1'b0, 1'b0, 4'd0, 16'd1, 16'd1};
    vecs[11] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 4'd0, 16'd1, 16'd1};
    vecs[12] = '{1'b1, 32'h00000003, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 4'd0, 16'd1, 16'd2};
    vecs[13] = '{1'b1, 32'h0003100E, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 4'd1, 16'd1, 16'd2};
    vecs[14] = '{1'b1, 32'h0000003F, 1'b0, 1'b0, 32'h0003100E, 1'b1, 1'b1, 4'd0, 16'd2, 16'd3};
    vecs[15] = '{1'b1, 32'hFFE00004, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 4'd1, 16'd2, 16'd3};
    vecs[16] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 32'hFFE00004, 1'b1, 1'b0, 4'd0, 16'd3, 16'd3};
    vecs[17] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 4'd0, 16'd3, 16'd3};

    // Reset state
    do_reset();
    chk("rst_core", a_core, 32'h0);
    chk("rst_level", 32'(a_lvl), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_ready", 32'(a_ready), 32'd1);
    $display("txn reset core=%h level=%0d ready=%0b", a_core, a_lvl, a_ready);

    // Table: single issue, illegal filtering, flush at level 5, opcode boundaries
    for (int i = 0; i < 18; i++) begin
      in_valid = vecs[i].v; in_instr = vecs[i].instr; hold = vecs[i].h; flush = vecs[i].f;
      step();
      chk($sformatf("v%0d_core", i), a_core, vecs[i].e_core);
      chk($sformatf("v%0d_iv", i), 32'(a_iv), 32'(vecs[i].e_iv));
      chk($sformatf("v%0d_ip", i), 32'(a_ip), 32'(vecs[i].e_ip));
      chk($sformatf("v%0d_lvl", i), 32'(a_lvl), 32'(vecs[i].e_lvl));
      chk($sformatf("v%0d_iss", i), 32'(a_iss), 32'(vecs[i].e_iss));
      chk($sformatf("v%0d_ill", i), 32'(a_ill), 32'(vecs[i].e_ill));
      $display("txn vec%0d in=%h v=%0b h=%0b f=%0b core=%h iv=%0b ip=%0b lvl=%0d iss=%0d ill=%0d",
               i, vecs[i].instr, vecs[i].v, vecs[i].h, vecs[i].f, a_core, a_iv, a_ip, a_lvl, a_iss, a_ill);
    end

    // Asynchronous reset while an instruction is in flight
    in_valid = 1'b1; in_instr = 32'h00000005; hold = 1'b0;
    step();
    in_instr = 32'h00000006;
    step();
    in_valid = 1'b0;
    chk("pre_rst_core", a_core, 32'h00000005);
    chk("pre_rst_lvl", 32'(a_lvl), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_core", a_core, 32'h0);
    chk("arst_lvl", 32'(a_lvl), 32'd0);
    chk("arst_iss", 32'(a_iss), 32'd0);
    chk("arst_ill", 32'(a_ill), 32'd0);
    chk("arst_iv", 32'(a_iv), 32'd0);
    $display("txn async_reset core=%h lvl=%0d iss=%0d ill=%0d", a_core, a_lvl, a_iss, a_ill);
    #3 rst_n = 1'b1;
    step();
    chk("rel_ready", 32'(a_ready), 32'd1);

    // Fill to full under hold, then drain back-to-back
    hold = 1'b1;
    acc_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_instr = (32'(i) << 16) | 32'(4 + i);
      if (a_ready) begin
        acc_cnt++;
        exp_q.push_back(in_instr);
      end
      step();
      $display("txn fill%0d in=%h lvl=%0d ready=%0b", i, in_instr, a_lvl, a_ready);
    end
    chk("fill_accepted", 32'(acc_cnt), 32'd8);
    chk("fill_lvl", 32'(a_lvl), 32'd8);
    chk("full_ready", 32'(a_ready), 32'd0);
    in_valid = 1'b0; hold = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("drain%0d_core", k), a_core, (k < exp_q.size()) ? exp_q[k] : 32'hDEAD_BEEF);
      chk($sformatf("drain%0d_iv", k), 32'(a_iv), 32'd1);
      $display("txn drain%0d core=%h iv=%0b lvl=%0d", k, a_core, a_iv, a_lvl);
    end
    step();
    chk("drain_end_core", a_core, 32'h0);
    chk("drain_end_iv", 32'(a_iv), 32'd0);
    chk("drain_iss", 32'(a_iss), 32'd8);

    // ISSUE_CYCLES=3: two instructions, 2-cycle hold during the second
    do_reset();
    b_exp_core = '{32'h0, 32'h00001111 & 32'hFFFF_FFC0 | 32'h4, 32'h00001104, 32'h00001104,
                   32'h0000220E, 32'h0000220E, 32'h0000220E, 32'h0000220E, 32'h0000220E, 32'h0};
    b_exp_iv   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int c = 1; c <= 10; c++) begin
      in_valid = (c <= 2);
      in_instr = (c == 1) ? 32'h00001104 : 32'h0000220E;
      hold = (c == 6 || c == 7);
      step();
      chk($sformatf("ic3_c%0d_core", c), b_core, b_exp_core[c]);
      chk($sformatf("ic3_c%0d_iv", c), 32'(b_iv), 32'(b_exp_iv[c]));
      $display("txn ic3 cyc%0d hold=%0b core=%h iv=%0b", c, hold, b_core, b_iv);
    end
    chk("ic3_iss", 32'(b_iss), 32'd2);
    chk("ic3_busy", 32'(b_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
